bar_height_scheduler: RTL

Frame-synchronous controller that owns the ten spectrum-bar heights consumed by the VGA colour mapper. It accepts per-band magnitude samples from the spectrum front end and records the maximum per band over the current video frame. Once per frame it sequences an update pass that applies attack/decay ballistics and peak-hold markers. It then publishes stable heights for the next displayed frame.

---
 rtl/bar_height_scheduler_if.sv | 20 ++
 rtl/bar_height_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bar_height_scheduler_if.sv
// ---------------------------------------------------------------------------
// bar_height_scheduler_if
// Valid/ready handshake that carries per-band magnitude samples from the
// spectrum front end into the bar-height scheduler.
//   mag_valid  source -> sink   sample valid
//   mag_ready  sink   -> source scheduler can accept a sample
//   mag_band   source -> sink   band index of the sample
//   mag_value  source -> sink   unsigned magnitude
// ---------------------------------------------------------------------------
interface bar_height_scheduler_if #(
    parameter int MAG_W = 16
) ();
    logic             mag_valid;
    logic             mag_ready;
    logic [3:0]       mag_band;
    logic [MAG_W-1:0] mag_value;

    modport master (output mag_valid, output mag_band, output mag_value, input  mag_ready);
    modport slave  (input  mag_valid, input  mag_band, input  mag_value, output mag_ready);
endinterface

// File: rtl/bar_height_scheduler.sv
// ---------------------------------------------------------------------------
// bar_height_scheduler
// Collects the per-band maximum magnitude over a video frame, then on each
// frame_tick walks the bars once (one bar per cycle) applying attack/decay
// ballistics and peak-hold markers, and publishes the resulting heights.
//   Clk           system clock
//   Reset         synchronous, active-high reset
//   frame_tick    one-cycle pulse at start of vertical blanking
//   mag           sample handshake (slave side)
//   bar_heights   bar i height in bits [10i+9:10i]
//   peak_heights  peak-marker height per bar, same packing
//   busy          update pass in progress
//   frame_done    one-cycle pulse after the last bar is updated
//   overrun       sticky: frame_tick arrived while a pass was running
// ---------------------------------------------------------------------------
module bar_height_scheduler #(
    parameter int NUM_BARS    = 10,
    parameter int MAG_W       = 16,
    parameter int SCALE_SHIFT = 6,
    parameter int MAX_H       = 420,
    parameter int DECAY       = 4,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_tick,
    bar_height_scheduler_if.slave    mag,
    output logic [NUM_BARS*10-1:0]   bar_heights,
    output logic [NUM_BARS*10-1:0]   peak_heights,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);
    localparam int         HOLD_W   = $clog2(HOLD_FRAMES + 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_BARS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_idx;
    logic                r_overrun;
    logic [MAG_W-1:0]    r_pending [NUM_BARS];
    logic [9:0]          r_height  [NUM_BARS];
    logic [9:0]          r_peak    [NUM_BARS];
    logic [HOLD_W-1:0]   r_hold    [NUM_BARS];

    logic                w_mag_ready;
    logic                w_busy;
    logic                w_frame_done;
    logic [MAG_W-1:0]    w_scaled;
    logic [9:0]          w_target;
    logic [9:0]          w_cur_h;
    logic [9:0]          w_cur_p;
    logic [HOLD_W-1:0]   w_cur_hold;
    logic [9:0]          w_new_h;
    logic [9:0]          w_new_p;
    logic [HOLD_W-1:0]   w_new_hold;

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_mag_ready  = 1'b0;
        w_busy       = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mag_ready = 1'b1;
                if (frame_tick) w_next_state = S_UPDATE;
            end
            S_UPDATE: begin
                w_busy = 1'b1;
                if (r_idx == LAST_IDX) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_frame_done = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign mag.mag_ready = w_mag_ready;
    assign busy          = w_busy;
    assign frame_done    = w_frame_done;
    assign overrun       = r_overrun;

    // ---------------- per-bar ballistics for bar r_idx ----------------
    always_comb begin
        w_cur_h    = r_height[r_idx];
        w_cur_p    = r_peak[r_idx];
        w_cur_hold = r_hold[r_idx];
        // Clamp at full magnitude width so large samples cannot wrap into
        // a small 10-bit height.
        w_scaled   = r_pending[r_idx] >> SCALE_SHIFT;
        w_target   = (w_scaled > MAG_W'(MAX_H)) ? 10'(MAX_H) : 10'(w_scaled);

        if (w_target >= w_cur_h)
            w_new_h = w_target;
        else if ({1'b0, w_cur_h} >= ({1'b0, w_target} + 11'(DECAY)))
            w_new_h = w_cur_h - 10'(DECAY);
        else
            w_new_h = w_target;   // decay step would cross the target (or zero)

        w_new_p    = w_cur_p;
        w_new_hold = w_cur_hold;
        if (w_new_h >= w_cur_p) begin
            w_new_p    = w_new_h;
            w_new_hold = HOLD_W'(HOLD_FRAMES);
        end else if (w_cur_hold != '0) begin
            w_new_hold = w_cur_hold - 1'b1;
        end else begin
            // peak > new height here, so peak >= 1 and cannot underflow
            w_new_p = ((w_cur_p - 10'd1) > w_new_h) ? (w_cur_p - 10'd1) : w_new_h;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_idx     <= '0;
            r_overrun <= 1'b0;
            // NOTE: these arrays are explicitly reset because both the
            // displayed heights and the ballistics history must start at zero;
            // they are small register banks, not RAM macros.
            for (int b = 0; b < NUM_BARS; b++) begin
                r_pending[b] <= '0;
                r_height[b]  <= '0;
                r_peak[b]    <= '0;
                r_hold[b]    <= '0;
            end
        end else begin
            if (frame_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    // Out-of-range bands are accepted but dropped.
                    if (mag.mag_valid && w_mag_ready && (int'(mag.mag_band) < NUM_BARS)) begin
                        if (mag.mag_value > r_pending[mag.mag_band])
                            r_pending[mag.mag_band] <= mag.mag_value;
                    end
                end
                S_UPDATE: begin
                    r_height[r_idx]  <= w_new_h;
                    r_peak[r_idx]    <= w_new_p;
                    r_hold[r_idx]    <= w_new_hold;
                    r_pending[r_idx] <= '0;
                    r_idx            <= r_idx + 4'd1;
                end
                default: r_idx <= '0;
            endcase
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BARS; b++) begin
            bar_heights[b*10 +: 10]  = r_height[b];
            peak_heights[b*10 +: 10] = r_peak[b];
        end
    end
endmodule
